irb_pingpong_buffer: RTL and testbench
======================================

Name: irb_pingpong_buffer

Overview:
Parametrised N-bank tile buffer that sits between the DMA (producer) and a convolution engine (consumer). It replaces the fixed single on-chip RAM plus address-select muxing used at the block top today. The DMA fills one bank while the engine reads another, so tile load overlaps compute. Bank hand-over uses explicit done/ready handshakes, and misuse is reported through sticky error flags.

Parameters:
DATA_W, 16, word width; matches PX_W.
DEPTH, 1024, words per bank; power of two, at least 2.
NBANK, 2, number of banks; 2..4.
ADDR_W, $clog2(DEPTH), bank-local address width; derived, not overridden.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
flush  in  1  synchronous clear of bank bookkeeping.
wr_en  in  1  producer write strobe.
wr_addr  in  ADDR_W  bank-local write address.
wr_data  in  DATA_W  write data.
wr_done  in  1  producer has finished the current bank.
wr_ready  out  1  a bank is available for filling.
wr_bank  out  $clog2(NBANK)  bank currently being filled.
rd_en  in  1  consumer read strobe.
rd_addr  in  ADDR_W  bank-local read address.
rd_done  in  1  consumer releases the current bank.
rd_ready  out  1  a full bank is available.
rd_bank  out  $clog2(NBANK)  bank currently being read.
rd_data  out  DATA_W  registered read data.
rd_valid  out  1  rd_data valid this cycle.
n_full  out  $clog2(NBANK+1)  number of full banks.
err_wr  out  1  sticky: wr_en or wr_done seen while wr_ready=0.
err_rd  out  1  sticky: rd_en or rd_done seen while rd_ready=0.

Behaviour:
- Reset (rst=0, asynchronous) sets wp=0, cp=0, n_full=0, rd_data=0, rd_valid=0, err_wr=0, err_rd=0. RAM contents are not reset. The same applies when rst is asserted mid-transfer: all in-flight state is discarded.
- Bookkeeping: write pointer wp, read pointer cp, counter n_full. wr_bank=wp, rd_bank=cp. wr_ready = (n_full != NBANK). rd_ready = (n_full != 0). All outputs are combinational from registers.
- Write: if wr_en and wr_ready, mem[wp][wr_addr] <= wr_data on the same edge. If wr_en while not wr_ready, no write occurs and err_wr is set.
- Read: if rd_en and rd_ready, the next cycle gives rd_data = mem[cp][rd_addr] and rd_valid=1 (latency 1). Otherwise rd_valid=0 next cycle and rd_data holds its value. rd_en while not rd_ready sets err_rd.
- wr_done accepted (wr_ready=1): wp <= (wp+1) mod NBANK, n_full+1.
- rd_done accepted (rd_ready=1): cp <= (cp+1) mod NBANK, n_full-1.
- Both done strobes accepted in the same cycle: both pointers advance and n_full is unchanged.
- A done strobe that is not accepted is ignored and sets the matching error flag.
- Pointer wrap is modulo NBANK, not power of two; NBANK=3 must wrap 2->0.
- Write and read on the same edge in one bank cannot occur: wp==cp only when n_full is 0 (reads blocked) or NBANK (writes blocked). No bypass logic is needed.
- A write to a bank in the same cycle as its wr_done is kept; the data lands before the hand-over.
- An rd_en issued in the same cycle as rd_done reads the old bank, cp, and returns next cycle.
- flush=1 has priority over everything except rst. It sets wp=cp=0 and n_full=0, clears rd_valid and both error flags, and ignores all strobes in that cycle.
- n_full saturates by construction. wr_done at NBANK and rd_done at 0 are rejected as above.

Decomposition:
- irb_pkg gains IRB_NBANK_MAX=4 and the default for DATA_W (=PX_W).
- Bank index width and the NBANK range check live in the package as localparam functions.
- One natural sub-module, irb_ram_bank: simple dual-port RAM, DEPTH x DATA_W, synchronous write, registered read, no reset. It is instantiated NBANK times with a generate loop.
- Write enables are decoded by wp. The read address is broadcast to all banks, and the output mux is selected by a registered copy of cp.

Test Plan:
- Reset then idle, NBANK=2 -> wr_ready=1, rd_ready=0, n_full=0, rd_valid=0, no error flags.
- Fill bank0 with addr i, data 16'h1000+i for i=0..15; pulse wr_done; read addr 5 -> wr_bank=1, n_full=1, next cycle rd_data=16'h1005, rd_valid=1.
- Fill both banks, then wr_en plus wr_done -> wr_ready=0, memory unchanged, err_wr=1, n_full stays 2.
- n_full=1, wr_done and rd_done in the same cycle -> n_full=1, wp=0, cp=1, no error flags.
- NBANK=3, four fill/drain rounds with data tagged by round -> pointers wrap 2->0 and each read returns its round's tag (e.g. round 3 reads 16'h3xxx from bank0).
- Assert rst low mid-fill with n_full=1, and separately pulse flush -> both give n_full=0, wp=cp=0, rd_valid=0, err flags cleared. rd_data=0 only after rst.

Source files
------------

// File: rtl/irb_pkg.sv
// Shared constants and elaboration helpers for the tile buffer (irb) blocks.
// Sizing functions are evaluated at elaboration to derive port widths.
package irb_pkg;

  localparam int PX_W           = 16;
  localparam int IRB_DATA_W_DEF = PX_W;
  localparam int IRB_NBANK_MAX  = 4;

  // Bank index width; never narrower than one bit so NBANK=2 still has a pointer.
  function automatic int irb_bank_w(input int nbank);
    return (nbank <= 2) ? 1 : $clog2(nbank);
  endfunction

  function automatic bit irb_nbank_ok(input int nbank);
    return (nbank >= 2) && (nbank <= IRB_NBANK_MAX);
  endfunction

endpackage

// File: rtl/irb_ram_bank.sv
// Simple dual-port RAM bank: synchronous write, registered read, no reset.
// Read data only updates on re_i, so the output holds between reads.
module irb_ram_bank #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/irb_pingpong_buffer.sv
// N-bank tile buffer between DMA producer and convolution consumer.
// Producer fills bank wp while consumer reads bank cp; done strobes hand banks over.
module irb_pingpong_buffer
  import irb_pkg::*;
#(
  parameter  int DATA_W = IRB_DATA_W_DEF,
  parameter  int DEPTH  = 1024,
  parameter  int NBANK  = 2,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BANK_W = irb_bank_w(NBANK),
  localparam int CNT_W  = $clog2(NBANK + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_done_i,
  output logic              wr_ready_o,
  output logic [BANK_W-1:0] wr_bank_o,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_done_i,
  output logic              rd_ready_o,
  output logic [BANK_W-1:0] rd_bank_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [CNT_W-1:0]  n_full_o,
  output logic              err_wr_o,
  output logic              err_rd_o
);

  if (!irb_nbank_ok(NBANK)) begin : g_bad_nbank
    $error("irb_pingpong_buffer: NBANK out of range");
  end

  logic [BANK_W-1:0] wp_q, wp_d, cp_q, cp_d, sel_q, sel_d;
  logic [CNT_W-1:0]  nfull_q, nfull_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_wr_q, err_wr_d, err_rd_q, err_rd_d;
  logic [DATA_W-1:0] rd_hold_q;
  logic              wr_acc, rd_acc, wdone_acc, rdone_acc;
  logic [DATA_W-1:0] bank_rdata [NBANK];

  assign wr_ready_o = (nfull_q != CNT_W'(NBANK));
  assign rd_ready_o = (nfull_q != '0);
  assign wr_bank_o  = wp_q;
  assign rd_bank_o  = cp_q;
  assign n_full_o   = nfull_q;
  assign err_wr_o   = err_wr_q;
  assign err_rd_o   = err_rd_q;
  assign rd_valid_o = rd_valid_q;

  // Between reads the bank outputs are left alone; the hold register keeps rd_data stable
  // and supplies the reset value, since the RAM itself has no reset.
  assign rd_data_o  = rd_valid_q ? bank_rdata[sel_q] : rd_hold_q;

  assign wr_acc    = !flush_i && wr_en_i   && wr_ready_o;
  assign rd_acc    = !flush_i && rd_en_i   && rd_ready_o;
  assign wdone_acc = !flush_i && wr_done_i && wr_ready_o;
  assign rdone_acc = !flush_i && rd_done_i && rd_ready_o;

  always_comb begin
    wp_d       = wp_q;
    cp_d       = cp_q;
    nfull_d    = nfull_q;
    sel_d      = sel_q;
    rd_valid_d = rd_acc;
    err_wr_d   = err_wr_q | ((wr_en_i | wr_done_i) & ~wr_ready_o);
    err_rd_d   = err_rd_q | ((rd_en_i | rd_done_i) & ~rd_ready_o);
    if (rd_acc) begin
      sel_d = cp_q;
    end
    if (wdone_acc) begin
      wp_d = (wp_q == BANK_W'(NBANK - 1)) ? '0 : wp_q + 1'b1;
    end
    if (rdone_acc) begin
      cp_d = (cp_q == BANK_W'(NBANK - 1)) ? '0 : cp_q + 1'b1;
    end
    case ({wdone_acc, rdone_acc})
      2'b10:   nfull_d = nfull_q + 1'b1;
      2'b01:   nfull_d = nfull_q - 1'b1;
      default: nfull_d = nfull_q;
    endcase
    if (flush_i) begin
      wp_d       = '0;
      cp_d       = '0;
      nfull_d    = '0;
      rd_valid_d = 1'b0;
      err_wr_d   = 1'b0;
      err_rd_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q       <= '0;
      cp_q       <= '0;
      sel_q      <= '0;
      nfull_q    <= '0;
      rd_valid_q <= 1'b0;
      err_wr_q   <= 1'b0;
      err_rd_q   <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      wp_q       <= wp_d;
      cp_q       <= cp_d;
      sel_q      <= sel_d;
      nfull_q    <= nfull_d;
      rd_valid_q <= rd_valid_d;
      err_wr_q   <= err_wr_d;
      err_rd_q   <= err_rd_d;
      rd_hold_q  <= rd_data_o;
    end
  end

  // wp==cp only when reads or writes are blocked, so no write/read bypass is needed.
  for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
    irb_ram_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk_i   (clk_i),
      .we_i    (wr_acc && (wp_q == BANK_W'(gi))),
      .waddr_i (wr_addr_i),
      .wdata_i (wr_data_i),
      .re_i    (rd_acc),
      .raddr_i (rd_addr_i),
      .rdata_o (bank_rdata[gi])
    );
  end

endmodule

// File: tb/tb_irb_pingpong_buffer.sv
// Drives an NBANK=2 and an NBANK=3 buffer with shared stimulus and compares both
// against a per-instance behavioural model of banks, pointers and flags.
module tb_irb_pingpong_buffer;

  logic        clk = 1'b0;
  logic        rst_n, flush, wr_en, wr_done, rd_en, rd_done;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;

  logic        a_wr_ready, a_rd_ready, a_rd_valid, a_err_wr, a_err_rd;
  logic [0:0]  a_wr_bank, a_rd_bank;
  logic [1:0]  a_n_full;
  logic [15:0] a_rd_data;
  logic        b_wr_ready, b_rd_ready, b_rd_valid, b_err_wr, b_err_rd;
  logic [1:0]  b_wr_bank, b_rd_bank;
  logic [1:0]  b_n_full;
  logic [15:0] b_rd_data;

  always #5 clk = ~clk;

  irb_pingpong_buffer #(.DATA_W(16), .DEPTH(16), .NBANK(2)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_done_i(wr_done),
    .wr_ready_o(a_wr_ready), .wr_bank_o(a_wr_bank),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_done_i(rd_done),
    .rd_ready_o(a_rd_ready), .rd_bank_o(a_rd_bank), .rd_data_o(a_rd_data),
    .rd_valid_o(a_rd_valid), .n_full_o(a_n_full), .err_wr_o(a_err_wr), .err_rd_o(a_err_rd)
  );

  irb_pingpong_buffer #(.DATA_W(16), .DEPTH(16), .NBANK(3)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_done_i(wr_done),
    .wr_ready_o(b_wr_ready), .wr_bank_o(b_wr_bank),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_done_i(rd_done),
    .rd_ready_o(b_rd_ready), .rd_bank_o(b_rd_bank), .rd_data_o(b_rd_data),
    .rd_valid_o(b_rd_valid), .n_full_o(b_n_full), .err_wr_o(b_err_wr), .err_rd_o(b_err_rd)
  );

  int total = 0;
  int bad   = 0;

  int          nb_m [2] = '{2, 3};
  int          wp_m [2], cp_m [2], nf_m [2];
  logic [15:0] rd_m [2];
  bit          rv_m [2], ew_m [2], er_m [2];
  logic [15:0] mem_m [2][4][16];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      wp_m[k] = 0; cp_m[k] = 0; nf_m[k] = 0;
      rd_m[k] = '0; rv_m[k] = 0; ew_m[k] = 0; er_m[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit wrdy, rrdy, wda, rda;
      if (flush) begin
        wp_m[k] = 0; cp_m[k] = 0; nf_m[k] = 0;
        rv_m[k] = 0; ew_m[k] = 0; er_m[k] = 0;
      end else begin
        wrdy = (nf_m[k] != nb_m[k]);
        rrdy = (nf_m[k] != 0);
        if (rd_en && rrdy) begin
          rd_m[k] = mem_m[k][cp_m[k]][rd_addr];
          rv_m[k] = 1;
        end else begin
          rv_m[k] = 0;
        end
        if (wr_en && wrdy) mem_m[k][wp_m[k]][wr_addr] = wr_data;
        if ((wr_en || wr_done) && !wrdy) ew_m[k] = 1;
        if ((rd_en || rd_done) && !rrdy) er_m[k] = 1;
        wda = wr_done && wrdy;
        rda = rd_done && rrdy;
        if (wda) wp_m[k] = (wp_m[k] + 1) % nb_m[k];
        if (rda) cp_m[k] = (cp_m[k] + 1) % nb_m[k];
        nf_m[k] = nf_m[k] + int'(wda) - int'(rda);
      end
    end
  endtask

  task automatic cmp_inst(input int k, input string p, input logic wrdy, input logic [1:0] wb,
                          input logic rrdy, input logic [1:0] rb, input logic [15:0] rd,
                          input logic rv, input logic [1:0] nf, input logic ew, input logic er);
    check_val({p, ".wr_ready"}, 32'(wrdy), 32'(nf_m[k] != nb_m[k]));
    check_val({p, ".rd_ready"}, 32'(rrdy), 32'(nf_m[k] != 0));
    check_val({p, ".wr_bank"},  32'(wb),   32'(wp_m[k]));
    check_val({p, ".rd_bank"},  32'(rb),   32'(cp_m[k]));
    check_val({p, ".n_full"},   32'(nf),   32'(nf_m[k]));
    check_val({p, ".rd_valid"}, 32'(rv),   32'(rv_m[k]));
    check_val({p, ".rd_data"},  32'(rd),   32'(rd_m[k]));
    check_val({p, ".err_wr"},   32'(ew),   32'(ew_m[k]));
    check_val({p, ".err_rd"},   32'(er),   32'(er_m[k]));
  endtask

  task automatic cmp_all();
    cmp_inst(0, "a", a_wr_ready, {1'b0, a_wr_bank}, a_rd_ready, {1'b0, a_rd_bank},
             a_rd_data, a_rd_valid, a_n_full, a_err_wr, a_err_rd);
    cmp_inst(1, "b", b_wr_ready, b_wr_bank, b_rd_ready, b_rd_bank,
             b_rd_data, b_rd_valid, b_n_full, b_err_wr, b_err_rd);
  endtask

  task automatic clear_strobes();
    flush = 0; wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cmp_all();
    @(negedge clk);
    clear_strobes();
  endtask

  task automatic write_word(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
  endtask

  task automatic fill(input logic [15:0] base);
    for (int i = 0; i < 16; i++) write_word(4'(i), base + 16'(i));
    wr_done = 1;
    tick();
  endtask

  task automatic read_word(input logic [3:0] a, input logic release_bank);
    rd_en = 1; rd_addr = a; rd_done = release_bank;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    clear_strobes();
    model_reset();
    repeat (3) @(negedge clk);
    cmp_all();
    check_val("rst.a.wr_ready", 32'(a_wr_ready), 32'd1);
    check_val("rst.a.rd_ready", 32'(a_rd_ready), 32'd0);
    check_val("rst.a.rd_data",  32'(a_rd_data),  32'd0);
    rst_n = 1;
    tick();
    $display("reset/idle checked");

    // Write every bank of both instances once so the model knows all RAM contents.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) write_word(4'(i), 16'($urandom));
      wr_done = 1;
      tick();
    end
    for (int r = 0; r < 4; r++) begin
      rd_done = 1;
      tick();
    end
    flush = 1;
    tick();
    $display("memory preload done");

    fill(16'h1000);
    check_val("fill.a.wr_bank", 32'(a_wr_bank), 32'd1);
    check_val("fill.a.n_full",  32'(a_n_full),  32'd1);
    read_word(4'd5, 1'b0);
    check_val("rd5.a.rd_data",  32'(a_rd_data),  32'h1005);
    check_val("rd5.a.rd_valid", 32'(a_rd_valid), 32'd1);
    check_val("rd5.b.rd_data",  32'(b_rd_data),  32'h1005);
    $display("fill bank0 and read addr 5 done");

    fill(16'h2000);
    check_val("full.a.wr_ready", 32'(a_wr_ready), 32'd0);
    check_val("full.a.n_full",   32'(a_n_full),   32'd2);
    wr_en = 1; wr_addr = 4'd5; wr_data = 16'hBEEF; wr_done = 1;
    tick();
    check_val("ovf.a.err_wr", 32'(a_err_wr), 32'd1);
    check_val("ovf.a.n_full", 32'(a_n_full), 32'd2);
    check_val("ovf.b.n_full", 32'(b_n_full), 32'd3);
    check_val("ovf.b.err_wr", 32'(b_err_wr), 32'd0);
    read_word(4'd5, 1'b1);
    check_val("ovf.a.bank0", 32'(a_rd_data), 32'h1005);
    read_word(4'd5, 1'b1);
    check_val("ovf.a.bank1", 32'(a_rd_data), 32'h2005);
    $display("overfill rejection done");

    flush = 1;
    tick();
    fill(16'h4000);
    wr_done = 1; rd_done = 1;
    tick();
    check_val("both.a.n_full",  32'(a_n_full),  32'd1);
    check_val("both.a.wr_bank", 32'(a_wr_bank), 32'd0);
    check_val("both.a.rd_bank", 32'(a_rd_bank), 32'd1);
    check_val("both.a.err_wr",  32'(a_err_wr),  32'd0);
    check_val("both.a.err_rd",  32'(a_err_rd),  32'd0);
    check_val("both.b.wr_bank", 32'(b_wr_bank), 32'd2);
    $display("simultaneous done strobes done");

    flush = 1;
    tick();
    for (int r = 0; r < 4; r++) begin
      logic [15:0] tag;
      tag = 16'(r) << 12;
      fill(tag);
      check_val("round.b.rd_bank", 32'(b_rd_bank), 32'(r % 3));
      read_word(4'(r + 1), 1'b1);
      check_val("round.b.rd_data", 32'(b_rd_data), 32'(tag | 16'(r + 1)));
      check_val("round.a.rd_data", 32'(a_rd_data), 32'(tag | 16'(r + 1)));
      $display("round %0d read tag %0h", r, b_rd_data);
    end
    check_val("round.b.wrap", 32'(b_rd_bank), 32'd1);

    fill(16'h5000);
    write_word(4'd0, 16'h5A5A);
    read_word(4'd2, 1'b0);
    #2 rst_n = 0;
    #1;
    model_reset();
    cmp_all();
    check_val("arst.a.rd_data", 32'(a_rd_data), 32'd0);
    check_val("arst.b.n_full",  32'(b_n_full),  32'd0);
    @(negedge clk);
    rst_n = 1;
    tick();
    $display("async reset mid-fill done");

    fill(16'h6000);
    read_word(4'd3, 1'b1);
    rd_done = 1;
    tick();
    check_val("fl.a.err_rd_pre", 32'(a_err_rd), 32'd1);
    flush = 1; wr_en = 1; wr_done = 1; rd_en = 1;
    tick();
    check_val("fl.a.err_rd",  32'(a_err_rd),  32'd0);
    check_val("fl.a.rd_data", 32'(a_rd_data), 32'h6003);
    check_val("fl.b.n_full",  32'(b_n_full),  32'd0);
    $display("flush done");

    for (int c = 0; c < 800; c++) begin
      wr_en   = ($urandom_range(0, 99) < 60);
      wr_done = ($urandom_range(0, 99) < 10);
      rd_en   = ($urandom_range(0, 99) < 50);
      rd_done = ($urandom_range(0, 99) < 12);
      flush   = ($urandom_range(0, 99) < 2);
      wr_addr = 4'($urandom);
      rd_addr = 4'($urandom);
      wr_data = 16'($urandom);
      tick();
    end
    $display("random phase done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
